pixl_fifo_wr_arbiter: RTL and testbench
=======================================

# pixl_fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the pixel FIFO among N pixel sources (camera line readers, test-pattern generator, DMA). Each granted source owns the port for one burst of up to BURST pixels, then the grant rotates. The block sits directly upstream of the FIFO. It drives the FIFO's `wr`/`wdata` and observes its `full` flag. It never reads the FIFO.

## Interface
- `B`, 8: pixel width in bits; matches the FIFO data width.
- `N`, 4: number of requesters, 2..8.
- `BURST`, 16: maximum pixels per grant, 1..255.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input N: per-source request; held high while the source has pixels.
- `valid` input N: per-source pixel valid.
- `wdata` input N*B: per-source pixel; source i occupies bits [i*B +: B].
- `ready` output N: per-source accept; a beat transfers when `valid[i] & ready[i]`.
- `grant` output N: one-hot owner of the port; all zero when idle.
- `busy` output 1: high while in BURST.
- `fifo_full` input 1: FIFO full flag.
- `fifo_wr` output 1: FIFO write strobe.
- `fifo_wdata` output B: FIFO write data.

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If `req` != 0, pick the winner by round-robin, starting at index `last+1` mod N.
  - Register one-hot `grant`, load the beat counter to 0, set `last` to the winner, go to BURST.
- BURST, with owner g:
  - `ready[g] = req[g] & ~fifo_full`; all other `ready` bits are 0.
  - `fifo_wr = valid[g] & ready[g]`; `fifo_wdata = wdata[g]` (combinational mux).
  - Each beat increments the counter.
- Burst end: at the clock edge where either (a beat occurs and the counter reaches BURST) or `req[g]` is low. The FSM then returns to IDLE and `grant` clears.
- `fifo_full` stalls the burst. The counter holds, the grant holds, and no beat is lost or duplicated.
- Beat counter width: $clog2(BURST+1). It never exceeds BURST.
- `valid` without `req` on the owner is ignored; `ready` is 0.
- Non-owner `valid`/`req` never affect the FIFO.
- Reset (any time, including mid-burst):
  - State = IDLE, `grant` = 0, counter = 0, `last` = N-1, so source 0 wins first.
  - Outputs during reset: `ready` = 0, `busy` = 0, `fifo_wr` = 0.
  - `fifo_wdata` = `wdata[0]` (don't-care; the bench must not check it).

## Timing
- Arbitration latency: `req` high in IDLE at edge k gives `grant`/`busy` high after edge k; the first beat is possible in cycle k+1.
- `fifo_wr`/`fifo_wdata` are combinational from `valid`, `fifo_full` and the registered grant. No extra pipeline stage; the FIFO registers the write.
- There is one mandatory IDLE cycle between consecutive bursts, including back-to-back bursts from the same sole requester.
- Peak throughput: BURST beats per BURST+1 cycles.
- Simultaneous requests are resolved only in IDLE, strictly by the round-robin order.

## Configuration
- `PIXL_ARB_PRIO0_EN`
  - Defined: source 0 is high priority. In IDLE, `req[0]` wins regardless of `last`. `last` is not updated by a priority-0 grant. The remaining sources rotate among themselves.
  - Undefined: pure round-robin across all N sources.
- Burst length and end rules are identical in both builds.

## Structure
- Package `pixl_arb_pkg`:
  - State typedef (IDLE, BURST).
  - Default constants for N and BURST.
  - `ONEHOT0` helper constant for the reset value of `grant`.
- Sub-module `pixl_rr_pick`: combinational round-robin picker.
  - Inputs: `req[N]`, `last` index.
  - Outputs: one-hot `win[N]`, `win_idx`, `any`.
  - Reused by later read-side schedulers.
- Top level holds the FSM, counter, `last` register and data mux.

## Test plan
- Reset release, `req`=4'b0110, all valid, FIFO not full:
  - `grant`=4'b0010 after one edge.
  - 16 writes of `wdata[1]`.
  - One IDLE cycle.
  - Then `grant`=4'b0100.
- Single source 3 requesting continuously:
  - Bursts of exactly 16 beats separated by one idle cycle.
  - `fifo_wr` duty 16/17.
- `fifo_full` asserted for 5 cycles after beat 7:
  - `ready`=0 and `fifo_wr`=0 during the stall; counter holds.
  - Burst completes with exactly 16 writes in total and no duplicate data.
- Owner drops `req` after beat 3:
  - Burst ends at that edge with 3 writes; `grant` clears.
  - Next requester in rotation is granted after one IDLE cycle.
- `reset_n` pulsed low mid-burst at beat 9:
  - `grant`=0, `busy`=0, `fifo_wr`=0 immediately (asynchronous).
  - After release, source 0 wins first if requesting.
- With `PIXL_ARB_PRIO0_EN`, all four sources requesting:
  - Source 0 granted on every arbitration while `req[0]` is high.
  - Sources 1–3 rotate in the arbitration cycles where `req[0]` is low.

Source files
------------

// File: rtl/pixl_arb_pkg.sv
// Shared types and defaults for the pixel FIFO write arbiter.
// Optional feature macro: PIXL_ARB_PRIO0_EN (source 0 high priority).
package pixl_arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } arb_state_e;

  localparam int B_DEF     = 8;
  localparam int N_DEF     = 4;
  localparam int BURST_DEF = 16;

  // Reset / idle value of the one-hot grant vector (up to 8 sources).
  localparam logic [7:0] ONEHOT0 = 8'h00;

endpackage

// File: rtl/pixl_fifo_wr_arbiter_if.sv
// Source-side and FIFO-side bundle of the pixel FIFO write arbiter.
// Optional feature macro: PIXL_ARB_PRIO0_EN (no effect on this file).
interface pixl_fifo_wr_arbiter_if
  import pixl_arb_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int N = N_DEF
);

  logic [N-1:0]   req;
  logic [N-1:0]   valid;
  logic [N*B-1:0] wdata;
  logic [N-1:0]   ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           fifo_full;
  logic           fifo_wr;
  logic [B-1:0]   fifo_wdata;

  modport master (
    input  req, valid, wdata, fifo_full,
    output ready, grant, busy,
    output fifo_wr, fifo_wdata
  );

  modport slave (
    output req, valid, wdata, fifo_full,
    input  ready, grant, busy,
    input  fifo_wr, fifo_wdata
  );

endinterface

// File: rtl/pixl_rr_pick.sv
// Combinational round-robin picker: first request after `last`.
// Optional feature macro: PIXL_ARB_PRIO0_EN (no effect on this file).
module pixl_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Scan last+1 .. last+N (mod N) and keep the first hit.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!any && req[j]) begin
        any     = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end

endmodule

// File: rtl/pixl_fifo_wr_arbiter.sv
// Round-robin burst arbiter for the pixel FIFO write port.
// Optional feature macro: PIXL_ARB_PRIO0_EN (source 0 high priority).
module pixl_fifo_wr_arbiter
  import pixl_arb_pkg::*;
#(
  parameter int B     = B_DEF,
  parameter int N     = N_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pixl_fifo_wr_arbiter_if.master bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST + 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [N-1:0]  pick_req;
  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic          any;
  logic          p0_win;
  logic          own_req;
  logic          beat;
  logic          last_beat;

`ifdef PIXL_ARB_PRIO0_EN
  assign p0_win   = bus.req[0];
  assign pick_req = bus.req & ~N'(1);
`else
  assign p0_win   = 1'b0;
  assign pick_req = bus.req;
`endif

  pixl_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (pick_req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign own_req   = |(bus.req & grant_q);
  assign bus.ready = grant_q & bus.req
                   & {N{~bus.fifo_full}};
  assign beat      = |(bus.valid & bus.ready);
  assign last_beat = beat
                   && (cnt_q == CW'(BURST - 1));

  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q == S_BURST);
  assign bus.fifo_wr    = beat;
  assign bus.fifo_wdata = bus.wdata[idx_q*B +: B];

  // Arbitrate in IDLE, count beats and detect burst end in BURST.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (p0_win) begin
          state_d = S_BURST;
          grant_d = N'(1);
          cnt_d   = '0;
          idx_d   = '0;
        end else if (any) begin
          state_d = S_BURST;
          grant_d = win;
          cnt_d   = '0;
          last_d  = win_idx;
          idx_d   = win_idx;
        end
      end
      S_BURST: begin
        if (last_beat || !own_req) begin
          state_d = S_IDLE;
          grant_d = ONEHOT0[N-1:0];
          cnt_d   = '0;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = ONEHOT0[N-1:0];
        cnt_d   = '0;
      end
    endcase
  end

  // State, grant, beat counter and rotation pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= ONEHOT0[N-1:0];
      cnt_q   <= '0;
      last_q  <= IW'(N - 1);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_pixl_fifo_wr_arbiter.sv
// Directed self-checking bench for pixl_fifo_wr_arbiter.
// Optional feature macro: PIXL_ARB_PRIO0_EN (adds priority checks).
module tb_pixl_fifo_wr_arbiter;

  localparam int B     = 8;
  localparam int N     = 4;
  localparam int BURST = 16;

  typedef struct {
    logic [3:0] req;
    logic [3:0] valid;
    logic       full;
    logic [3:0] grant;
    logic [3:0] ready;
    logic       busy;
    logic       wr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] seq [N] = '{default: 8'd0};
  logic [7:0] wlog [$];

  always #5 clk = ~clk;

  pixl_fifo_wr_arbiter_if #(.B(B), .N(N)) bus ();

  pixl_fifo_wr_arbiter #(
    .B     (B),
    .N     (N),
    .BURST (BURST)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  // Source model: each source steps its pixel on an accepted beat.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (bus.valid[i] && bus.ready[i])
        seq[i] <= seq[i] + 8'd1;

  // Pixel of source i is {i, sequence number}.
  always_comb begin
    bus.wdata = '0;
    for (int i = 0; i < N; i++)
      bus.wdata[i*B +: B] = {2'(i), seq[i][5:0]};
  end

  // Record every FIFO write.
  always @(negedge clk)
    if (bus.fifo_wr === 1'b1)
      wlog.push_back(bus.fifo_wdata);

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int off,
                         input int src, input int start,
                         input int n);
    int idx;
    for (int j = 0; j < n; j++) begin
      idx = off + j;
      chk(nm,
          (idx < wlog.size()) ? 32'(wlog[idx])
                              : 32'hFFFF_FFFF,
          32'({2'(src), 6'(start + j)}));
    end
  endtask

`ifdef PIXL_ARB_PRIO0_EN
  task automatic one_burst(output logic [3:0] g);
    int n;
    n = 0;
    while (bus.grant == 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    g = bus.grant;
    n = 0;
    while (bus.grant != 4'b0000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("prio_burst_end", 32'(bus.grant), 32'h0);
  endtask
`endif

  initial begin
    vec_t       tv [21];
    logic [3:0] g4 [9];
    logic       w4 [9];
    int         base;
    logic       exp_wr;
    logic       stall;

    tv[0] = '{4'b0110, 4'b1111, 1'b0,
              4'b0000, 4'b0000, 1'b0, 1'b0};
    for (int r = 1; r <= 16; r++)
      tv[r] = '{4'b0110, 4'b1111, 1'b0,
                4'b0010, 4'b0010, 1'b1, 1'b1};
    tv[17] = '{4'b0110, 4'b1111, 1'b0,
               4'b0000, 4'b0000, 1'b0, 1'b0};
    tv[18] = '{4'b0110, 4'b1111, 1'b0,
               4'b0100, 4'b0100, 1'b1, 1'b1};
    tv[19] = '{4'b0000, 4'b1111, 1'b0,
               4'b0100, 4'b0000, 1'b1, 1'b0};
    tv[20] = '{4'b0000, 4'b1111, 1'b0,
               4'b0000, 4'b0000, 1'b0, 1'b0};

    g4 = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
           4'h0, 4'h8, 4'h8, 4'h0};
    w4 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state with everything requesting.
    bus.req       = 4'b1111;
    bus.valid     = 4'b1111;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_wr", 32'(bus.fifo_wr), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h0);
    bus.req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;

    // Table: two sources, full burst then rotation.
    base = wlog.size();
    for (int r = 0; r < 21; r++) begin
      @(posedge clk);
      #1;
      bus.req       = tv[r].req;
      bus.valid     = tv[r].valid;
      bus.fifo_full = tv[r].full;
      @(negedge clk);
      chk($sformatf("t1_grant[%0d]", r),
          32'(bus.grant), 32'(tv[r].grant));
      chk($sformatf("t1_ready[%0d]", r),
          32'(bus.ready), 32'(tv[r].ready));
      chk($sformatf("t1_busy[%0d]", r),
          32'(bus.busy), 32'(tv[r].busy));
      chk($sformatf("t1_wr[%0d]", r),
          32'(bus.fifo_wr), 32'(tv[r].wr));
    end
    chk("t1_count", 32'(wlog.size() - base), 32'd17);
    chk_log("t1_data_src1", base, 1, 0, 16);
    chk_log("t1_data_src2", base + 16, 2, 0, 1);

    // Sole requester 3: 16 beats, 1 idle, repeated.
    base = wlog.size();
    for (int c = 0; c < 52; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.req = 4'b1000;
      if (c == 51) bus.req = 4'b0000;
      @(negedge clk);
      exp_wr = (c % 17 != 0) && (c < 51);
      chk($sformatf("t2_wr[%0d]", c),
          32'(bus.fifo_wr), 32'(exp_wr));
    end
    chk("t2_count", 32'(wlog.size() - base), 32'd48);
    chk_log("t2_data_src3", base, 3, 0, 48);

    // FIFO full for 5 cycles after beat 7.
    base = wlog.size();
    for (int c = 0; c < 23; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.req = 4'b0010;
      if (c == 22) bus.req = 4'b0000;
      stall = (c >= 8) && (c <= 12);
      bus.fifo_full = stall;
      @(negedge clk);
      exp_wr = ((c >= 1) && (c <= 7))
            || ((c >= 13) && (c <= 21));
      chk($sformatf("t3_wr[%0d]", c),
          32'(bus.fifo_wr), 32'(exp_wr));
      if (stall) begin
        chk($sformatf("t3_ready[%0d]", c),
            32'(bus.ready), 32'h0);
        chk($sformatf("t3_grant[%0d]", c),
            32'(bus.grant), 32'h2);
      end
    end
    chk("t3_count", 32'(wlog.size() - base), 32'd16);
    chk_log("t3_data_src1", base, 1, 16, 16);

    // Owner drops req after beat 3.
    base = wlog.size();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.req = 4'b1100;
      if (c == 4) bus.req = 4'b1000;
      if (c == 7) bus.req = 4'b0000;
      @(negedge clk);
      chk($sformatf("t4_grant[%0d]", c),
          32'(bus.grant), 32'(g4[c]));
      chk($sformatf("t4_wr[%0d]", c),
          32'(bus.fifo_wr), 32'(w4[c]));
    end
    chk("t4_count", 32'(wlog.size() - base), 32'd4);
    chk_log("t4_data_src2", base, 2, 1, 3);
    chk_log("t4_data_src3", base + 3, 3, 48, 1);

    // Reset pulse mid-burst at beat 9.
    base = wlog.size();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.req = 4'b0011;
      @(negedge clk);
      chk($sformatf("t5_wr[%0d]", c),
          32'(bus.fifo_wr), 32'(c >= 1));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(bus.grant), 32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    chk("t5_rst_wr", 32'(bus.fifo_wr), 32'h0);
    chk("t5_rst_ready", 32'(bus.ready), 32'h0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t5_regrant", 32'(bus.grant), 32'h1);
    chk("t5_busy", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_end_grant", 32'(bus.grant), 32'h0);
    chk("t5_end_busy", 32'(bus.busy), 32'h0);
    chk("t5_count", 32'(wlog.size() - base), 32'd9);
    chk_log("t5_data_src0", base, 0, 0, 9);

`ifdef PIXL_ARB_PRIO0_EN
    begin
      logic [3:0] pr [8];
      logic [3:0] pg [8];
      logic [3:0] g;
      pr = '{4'hF, 4'hF, 4'hE, 4'hE,
             4'hE, 4'hE, 4'hF, 4'hE};
      pg = '{4'h1, 4'h1, 4'h2, 4'h4,
             4'h8, 4'h2, 4'h1, 4'h4};
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      bus.valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
        bus.req = pr[i];
        one_burst(g);
        chk($sformatf("prio_grant[%0d]", i),
            32'(g), 32'(pg[i]));
      end
      bus.req = 4'b0000;
    end
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
